// File: rtl/chess_clock_ctrl.sv
// rtl/chess_clock_ctrl.sv - two-player chess clock with Fischer increment, Avalon-MM slave
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   tick_in              timer irq level; each rising edge is one tick
//   address/chipselect/write_n/read_n/writedata  Avalon-MM slave inputs
//   readdata             registered read data, valid one cycle after address
//   irq                  irq_pending & irq_en
//   tick_ack             one-cycle pulse per detected tick edge
module chess_clock_ctrl #(
    parameter logic [31:0] DEFAULT_TIME = 32'd300000,
    parameter logic [31:0] INCREMENT    = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_in,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    output logic        tick_ack
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLAGGED} state_t;

    state_t      state_q, state_d;
    logic        side_q, side_d;              // 0 = WHITE, 1 = BLACK
    logic [31:0] white_cnt_q, white_cnt_d;
    logic [31:0] black_cnt_q, black_cnt_d;
    logic [31:0] preload_q, preload_d;
    logic        white_flag_q, white_flag_d;
    logic        black_flag_q, black_flag_d;
    logic        irq_en_q, irq_en_d;
    logic        irq_pending_q, irq_pending_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] readdata_q, readdata_d;
    logic        tick_ack_q, tick_ack_d;
    logic        tick_d_q, tick_d_d;

    logic        wr, rd, ctrl_wr;
    logic        cmd_start, cmd_stop, cmd_switch, cmd_load;
    logic        tick_ev, running, do_load;
    logic [31:0] active_cnt, out_cnt;
    logic [32:0] incr_sum;

    assign tick_ev    = tick_in & ~tick_d_q;
    assign wr         = chipselect & ~write_n;
    assign rd         = chipselect & ~read_n;
    assign ctrl_wr    = wr && (address == 3'd1);
    assign cmd_start  = ctrl_wr & writedata[0];
    assign cmd_stop   = ctrl_wr & writedata[1];
    assign cmd_switch = ctrl_wr & writedata[2];
    assign cmd_load   = ctrl_wr & writedata[4];
    assign running    = (state_q == ST_RUN);
    assign active_cnt = side_q ? black_cnt_q : white_cnt_q;

    always_comb begin
        state_d       = state_q;
        side_d        = side_q;
        white_cnt_d   = white_cnt_q;
        black_cnt_d   = black_cnt_q;
        preload_d     = preload_q;
        white_flag_d  = white_flag_q;
        black_flag_d  = black_flag_q;
        irq_en_d      = irq_en_q;
        irq_pending_d = irq_pending_q;
        shadow_d      = shadow_q;
        readdata_d    = 16'h0000;
        tick_ack_d    = tick_ev;
        tick_d_d      = tick_in;
        do_load       = 1'b0;
        out_cnt       = active_cnt;
        incr_sum      = 33'd0;

        if (ctrl_wr)
            irq_en_d = writedata[3];
        if (wr && address == 3'd6)
            preload_d[15:0] = writedata;
        if (wr && address == 3'd7)
            preload_d[31:16] = writedata;
        // Clear first so that a flag event in the same cycle re-sets it.
        if (wr && address == 3'd0)
            irq_pending_d = 1'b0;

        if (rd && address == 3'd2)
            shadow_d = white_cnt_q[31:16];
        if (rd && address == 3'd4)
            shadow_d = black_cnt_q[31:16];

        case (state_q)
            ST_IDLE: begin
                if (cmd_load) begin
                    do_load = 1'b1;
                end else begin
                    if (cmd_switch)
                        side_d = ~side_q;
                    if (cmd_start && !cmd_stop && active_cnt != 32'd0)
                        state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A tick that reaches zero outranks SWITCH and STOP.
                if (tick_ev && active_cnt <= 32'd1) begin
                    out_cnt       = 32'd0;
                    irq_pending_d = 1'b1;
                    state_d       = ST_FLAGGED;
                    if (side_q) black_flag_d = 1'b1;
                    else        white_flag_d = 1'b1;
                end else begin
                    if (tick_ev)
                        out_cnt = active_cnt - 32'd1;
                    if (cmd_switch) begin
                        incr_sum = {1'b0, out_cnt} + {1'b0, INCREMENT};
                        out_cnt  = incr_sum[32] ? 32'hFFFF_FFFF : incr_sum[31:0];
                        side_d   = ~side_q;
                    end
                    if (cmd_stop)
                        state_d = ST_IDLE;
                end
                if (side_q) black_cnt_d = out_cnt;
                else        white_cnt_d = out_cnt;
            end
            ST_FLAGGED: begin
                if (cmd_load) begin
                    do_load = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_load) begin
            white_cnt_d  = preload_q;
            black_cnt_d  = preload_q;
            white_flag_d = 1'b0;
            black_flag_d = 1'b0;
            side_d       = 1'b0;
        end

        case (address)
            3'd0: readdata_d = {11'b0, irq_pending_q, black_flag_q, white_flag_q, side_q, running};
            3'd1: readdata_d = {12'b0, irq_en_q, 3'b0};
            3'd2: readdata_d = white_cnt_q[15:0];
            3'd3: readdata_d = shadow_q;
            3'd4: readdata_d = black_cnt_q[15:0];
            3'd5: readdata_d = shadow_q;
            3'd6: readdata_d = preload_q[15:0];
            3'd7: readdata_d = preload_q[31:16];
            default: readdata_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            side_q        <= 1'b0;
            white_cnt_q   <= DEFAULT_TIME;
            black_cnt_q   <= DEFAULT_TIME;
            preload_q     <= DEFAULT_TIME;
            white_flag_q  <= 1'b0;
            black_flag_q  <= 1'b0;
            irq_en_q      <= 1'b0;
            irq_pending_q <= 1'b0;
            shadow_q      <= 16'h0000;
            readdata_q    <= 16'h0000;
            tick_ack_q    <= 1'b0;
            tick_d_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            side_q        <= side_d;
            white_cnt_q   <= white_cnt_d;
            black_cnt_q   <= black_cnt_d;
            preload_q     <= preload_d;
            white_flag_q  <= white_flag_d;
            black_flag_q  <= black_flag_d;
            irq_en_q      <= irq_en_d;
            irq_pending_q <= irq_pending_d;
            shadow_q      <= shadow_d;
            readdata_q    <= readdata_d;
            tick_ack_q    <= tick_ack_d;
            tick_d_q      <= tick_d_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_pending_q & irq_en_q;
    assign tick_ack = tick_ack_q;

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// tb/tb_chess_clock_ctrl.sv - directed self-checking bench for chess_clock_ctrl
module tb_chess_clock_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick_in = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic        read_n = 1'b1;
    logic [15:0] writedata = 16'h0000;
    logic [15:0] readdata;
    logic        irq;
    logic        tick_ack;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] rdv;
    int          acks;

    chess_clock_ctrl #(.DEFAULT_TIME(32'd300000), .INCREMENT(32'd3)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_in    (tick_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .tick_ack   (tick_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic tick_pulse(input int high, output int ack_cnt);
        ack_cnt = 0;
        @(negedge clk);
        tick_in = 1'b1;
        for (int i = 0; i < high; i++) begin
            @(negedge clk);
            if (tick_ack) ack_cnt++;
        end
        tick_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
        logic [15:0] v;
        bus_read(a, v);
        check(tag, {16'h0, v}, {16'h0, exp});
    endtask

    initial begin
        // reset values
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_readdata", {16'h0, readdata}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_tick_ack", {31'h0, tick_ack}, 32'h0);
        rd_check("rst_white_lo", 3'd2, 16'h93E0);
        rd_check("rst_white_hi", 3'd3, 16'h0004);
        rd_check("rst_black_lo", 3'd4, 16'h93E0);
        rd_check("rst_black_hi", 3'd5, 16'h0004);
        rd_check("rst_status", 3'd0, 16'h0000);

        // preload 5, countdown to flag, irq
        bus_write(3'd6, 16'd5);
        bus_write(3'd7, 16'd0);
        bus_write(3'd1, 16'h0010);
        bus_write(3'd1, 16'h0009);
        rd_check("run_status", 3'd0, 16'h0001);
        rd_check("ctrl_readback", 3'd1, 16'h0008);
        for (int k = 0; k < 4; k++) tick_pulse(1, acks);
        rd_check("white_after4", 3'd2, 16'd1);
        tick_pulse(20, acks);
        check("long_pulse_acks", acks, 32'd1);
        rd_check("white_zero", 3'd2, 16'd0);
        rd_check("flag_status", 3'd0, 16'h0014);
        check("flag_irq", {31'h0, irq}, 32'h1);
        bus_write(3'd0, 16'h0000);
        check("irq_cleared", {31'h0, irq}, 32'h0);
        rd_check("status_after_clr", 3'd0, 16'h0004);

        // Fischer increment on SWITCH
        bus_write(3'd6, 16'd10);
        bus_write(3'd1, 16'h0018);
        bus_write(3'd1, 16'h0009);
        tick_pulse(1, acks);
        tick_pulse(1, acks);
        bus_write(3'd1, 16'h000C);
        rd_check("incr_white", 3'd2, 16'd11);
        rd_check("incr_status", 3'd0, 16'h0003);
        tick_pulse(1, acks);
        rd_check("black_after_tick", 3'd4, 16'd9);
        rd_check("white_held", 3'd2, 16'd11);

        // tick + SWITCH at white==1: flag wins
        bus_write(3'd1, 16'h000A);
        rd_check("stop_status", 3'd0, 16'h0002);
        bus_write(3'd6, 16'd2);
        bus_write(3'd1, 16'h0018);
        bus_write(3'd1, 16'h0009);
        tick_pulse(1, acks);
        rd_check("white_one", 3'd2, 16'd1);
        @(negedge clk);
        tick_in = 1'b1;
        chipselect = 1'b1; write_n = 1'b0; address = 3'd1; writedata = 16'h000C;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        tick_in = 1'b0;
        rd_check("simul_status", 3'd0, 16'h0014);
        rd_check("simul_white", 3'd2, 16'd0);
        rd_check("simul_black", 3'd4, 16'd2);
        bus_write(3'd1, 16'h0009);
        tick_pulse(1, acks);
        tick_pulse(1, acks);
        rd_check("frozen_white", 3'd2, 16'd0);
        rd_check("frozen_black", 3'd4, 16'd2);
        rd_check("frozen_status", 3'd0, 16'h0014);

        // shadow coherency across a carry
        bus_write(3'd6, 16'h0001);
        bus_write(3'd7, 16'h0001);
        bus_write(3'd1, 16'h0018);
        bus_write(3'd1, 16'h0009);
        tick_pulse(1, acks);
        rd_check("shadow_lo", 3'd2, 16'h0000);
        tick_pulse(1, acks);
        rd_check("shadow_hi", 3'd3, 16'h0001);
        rd_check("live_lo", 3'd2, 16'hFFFF);
        rd_check("live_hi", 3'd3, 16'h0000);

        // one-cycle reset mid-RUN
        check("pre_reset_irq", {31'h0, irq}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_readdata", {16'h0, readdata}, 32'h0);
        check("mid_rst_irq", {31'h0, irq}, 32'h0);
        rd_check("mid_rst_status", 3'd0, 16'h0000);
        rd_check("mid_rst_white", 3'd2, 16'h93E0);
        rd_check("mid_rst_black", 3'd4, 16'h93E0);
        rd_check("mid_rst_black_hi", 3'd5, 16'h0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
